// File: rtl/bintogray_pkg.sv
// Shared constants and pure binary/Gray conversion functions, sized to MAX_WIDTH.
// Callers zero-extend narrower words in, then truncate the result back.
package bintogray_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int MAX_WIDTH     = 32;

    function automatic logic [MAX_WIDTH-1:0] bin2gray_f(input logic [MAX_WIDTH-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Prefix XOR from the MSB down; leading zeros above a narrow word decode to zero.
    function automatic logic [MAX_WIDTH-1:0] gray2bin_f(input logic [MAX_WIDTH-1:0] gray);
        logic [MAX_WIDTH-1:0] bin;
        bin[MAX_WIDTH-1] = gray[MAX_WIDTH-1];
        for (int i = MAX_WIDTH - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational WIDTH-bit Gray-to-binary decoder.
// Latency: 0 cycles (pure logic). Backpressure: none.
// Flow: stateless; output follows input every cycle.
module gray_to_bin
    import bintogray_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    logic [MAX_WIDTH-1:0] gray_ext;
    logic [MAX_WIDTH-1:0] bin_ext;

    assign gray_ext = MAX_WIDTH'(gray);
    assign bin_ext  = gray2bin_f(gray_ext);
    assign bin      = bin_ext[WIDTH-1:0];

endmodule

// File: rtl/bin_to_gray.sv
// Registered binary-to-Gray converter; optional round-trip check under BINTOGRAY_CHECK_EN.
// Latency: 1 cycle from accept to g/out_valid; chk_err one cycle after that.
// Backpressure: none, accepts one word per clock whenever in_valid is high.
module bin_to_gray
    import bintogray_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] g,
    output logic             chk_err
);

    logic [MAX_WIDTH-1:0] b_ext;
    logic [MAX_WIDTH-1:0] g_ext;
    logic [WIDTH-1:0]     g_nxt;

    assign b_ext = MAX_WIDTH'(b);
    assign g_ext = bin2gray_f(b_ext);
    assign g_nxt = g_ext[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            g         <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                g <= g_nxt;
            end
        end
    end

`ifdef BINTOGRAY_CHECK_EN
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] g_dec;
    logic             chk_err_q;

    gray_to_bin #(.WIDTH(WIDTH)) u_dec (
        .gray (g),
        .bin  (g_dec)
    );

    // b_q shadows g exactly, so the compare is only meaningful while out_valid is high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            b_q       <= '0;
            chk_err_q <= 1'b0;
        end else begin
            if (in_valid) begin
                b_q <= b;
            end
            chk_err_q <= out_valid && (g_dec != b_q);
        end
    end

    assign chk_err = chk_err_q;
`else
    assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_bin_to_gray.sv
// Self-checking bench for bin_to_gray at WIDTH=4 and WIDTH=8 against a reflected-Gray table.
// Define BINTOGRAY_CHECK_EN to also exercise the round-trip check.
module tb_bin_to_gray;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       iv4, iv8;
    logic [3:0] b4;
    logic [7:0] b8;
    logic       ov4, ov8;
    logic [3:0] g4;
    logic [7:0] g8;
    logic       ce4, ce8;

    int passed = 0;
    int total  = 0;

    // Reflected Gray table: entry n is the Gray code for binary n.
    int gt[256];

    always #5 clk = ~clk;

    bin_to_gray #(.WIDTH(4)) u4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .b(b4),
        .out_valid(ov4), .g(g4), .chk_err(ce4)
    );

    bin_to_gray #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .b(b8),
        .out_valid(ov8), .g(g8), .chk_err(ce8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Build by reflect-and-prefix: mirror the existing list and set the next bit.
    task automatic build_table();
        int size;
        gt[0] = 0;
        size  = 1;
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < size; i++) begin
                gt[size + i] = gt[size - 1 - i] | (1 << k);
            end
            size = size * 2;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        iv4 = 1'b1; b4 = 4'($urandom);
        iv8 = 1'b1; b8 = 8'($urandom);
        tick();
        tick();
        total++;
        if (g4 !== 4'h0 || ov4 !== 1'b0 || ce4 !== 1'b0)
            $display("FAIL reset_w4 got g=%h v=%b e=%b exp g=0 v=0 e=0", g4, ov4, ce4);
        else passed++;
        total++;
        if (g8 !== 8'h00 || ov8 !== 1'b0 || ce8 !== 1'b0)
            $display("FAIL reset_w8 got g=%h v=%b e=%b exp g=00 v=0 e=0", g8, ov8, ce8);
        else passed++;
        rst_n = 1'b1;
        iv4 = 1'b0;
        iv8 = 1'b0;
        tick();
        total++;
        if (ov4 !== 1'b0 || g4 !== 4'h0)
            $display("FAIL idle_after_reset got g=%h v=%b exp g=0 v=0", g4, ov4);
        else passed++;
    endtask

    task automatic test_sweep();
        for (int n = 0; n < 16; n++) begin
            iv4 = 1'b1;
            b4  = 4'(n);
            tick();
            total++;
            if (g4 !== 4'(gt[n]) || ov4 !== 1'b1)
                $display("FAIL sweep_%0d got g=%h v=%b exp g=%h v=1", n, g4, ov4, 4'(gt[n]));
            else passed++;
        end
    endtask

    task automatic test_wrap();
        logic [3:0] prev;
        iv4 = 1'b1; b4 = 4'hF;
        tick();
        total++;
        if (g4 !== 4'b1000) $display("FAIL wrap_hi got g=%b exp 1000", g4);
        else passed++;
        prev = g4;
        b4 = 4'h0;
        tick();
        total++;
        if (g4 !== 4'b0000 || $countones(prev ^ g4) != 1)
            $display("FAIL wrap_lo got g=%b prev=%b exp 0000 single-bit step", g4, prev);
        else passed++;
    endtask

    task automatic test_idle_hold();
        iv4 = 1'b1; b4 = 4'd5;
        tick();
        total++;
        if (g4 !== 4'b0111 || ov4 !== 1'b1) $display("FAIL idle_load got g=%b v=%b exp 0111 v=1", g4, ov4);
        else passed++;
        iv4 = 1'b0;
        for (int c = 0; c < 3; c++) begin
            b4 = ~b4;
            tick();
            total++;
            if (g4 !== 4'b0111 || ov4 !== 1'b0)
                $display("FAIL idle_hold_%0d got g=%b v=%b exp 0111 v=0", c, g4, ov4);
            else passed++;
        end
    endtask

    task automatic test_reset_mid();
        iv4 = 1'b1; b4 = 4'd9;
        tick();
        total++;
        if (g4 !== 4'hD || ov4 !== 1'b1) $display("FAIL mid_pre got g=%h v=%b exp D v=1", g4, ov4);
        else passed++;
        rst_n = 1'b0; b4 = 4'd3;
        tick();
        total++;
        if (g4 !== 4'h0 || ov4 !== 1'b0) $display("FAIL mid_reset got g=%h v=%b exp 0 v=0", g4, ov4);
        else passed++;
        rst_n = 1'b1; iv4 = 1'b0;
        tick();
        total++;
        if (g4 !== 4'h0 || ov4 !== 1'b0) $display("FAIL mid_release got g=%h v=%b exp 0 v=0", g4, ov4);
        else passed++;
        iv4 = 1'b1; b4 = 4'd6;
        tick();
        total++;
        if (g4 !== 4'h5 || ov4 !== 1'b1) $display("FAIL mid_first got g=%h v=%b exp 5 v=1", g4, ov4);
        else passed++;
        iv4 = 1'b0;
    endtask

    task automatic test_width8();
        iv8 = 1'b1; b8 = 8'hFF;
        tick();
        total++;
        if (g8 !== 8'h80 || ov8 !== 1'b1) $display("FAIL w8_ff got g=%h v=%b exp 80 v=1", g8, ov8);
        else passed++;
        b8 = 8'h80;
        tick();
        total++;
        if (g8 !== 8'hC0 || ov8 !== 1'b1) $display("FAIL w8_80 got g=%h v=%b exp C0 v=1", g8, ov8);
        else passed++;
        iv8 = 1'b0;
        tick();
        total++;
        if (g8 !== 8'hC0 || ov8 !== 1'b0) $display("FAIL w8_hold got g=%h v=%b exp C0 v=0", g8, ov8);
        else passed++;
    endtask

    task automatic test_random();
        logic [3:0] eg4;
        logic [7:0] eg8;
        logic       ev4, ev8;
        int         bad4, bad8;
        eg4 = g4; eg8 = g8;
        bad4 = 0; bad8 = 0;
        for (int c = 0; c < 300; c++) begin
            iv4 = 1'($urandom_range(0, 1));
            iv8 = 1'($urandom_range(0, 1));
            b4  = 4'($urandom);
            b8  = 8'($urandom);
            if (iv4) eg4 = 4'(gt[b4]);
            if (iv8) eg8 = 8'(gt[b8]);
            ev4 = iv4;
            ev8 = iv8;
            tick();
            if (g4 !== eg4 || ov4 !== ev4 || ce4 !== 1'b0) begin
                if (bad4 < 5) $display("FAIL rand_w4_%0d got g=%h v=%b e=%b exp g=%h v=%b e=0", c, g4, ov4, ce4, eg4, ev4);
                bad4++;
            end
            if (g8 !== eg8 || ov8 !== ev8 || ce8 !== 1'b0) begin
                if (bad8 < 5) $display("FAIL rand_w8_%0d got g=%h v=%b e=%b exp g=%h v=%b e=0", c, g8, ov8, ce8, eg8, ev8);
                bad8++;
            end
        end
        total++;
        if (bad4 != 0) $display("FAIL rand_w4 got %0d bad cycles exp 0", bad4);
        else passed++;
        total++;
        if (bad8 != 0) $display("FAIL rand_w8 got %0d bad cycles exp 0", bad8);
        else passed++;
        iv4 = 1'b0;
        iv8 = 1'b0;
    endtask

`ifdef BINTOGRAY_CHECK_EN
    task automatic test_check();
        iv4 = 1'b1; b4 = 4'd10;
        tick();
        iv4 = 1'b0;
        force u4.g = 4'(gt[10]) ^ 4'b0001;
        tick();
        total++;
        if (ce4 !== 1'b1) $display("FAIL chk_detect got chk_err=%b exp 1", ce4);
        else passed++;
        release u4.g;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        total++;
        if (ce4 !== 1'b0) $display("FAIL chk_clear got chk_err=%b exp 0", ce4);
        else passed++;
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        iv4 = 1'b0; iv8 = 1'b0;
        b4 = '0; b8 = '0;
        build_table();
        test_reset();
        test_sweep();
        test_wrap();
        test_idle_hold();
        test_reset_mid();
        test_width8();
        test_random();
`ifdef BINTOGRAY_CHECK_EN
        test_check();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
